regfile_sb: RTL and testbench

- Parametrised successor to the 32x64 register file: configurable width and depth, plus a write-to-read bypass and a per-register busy scoreboard for the pipelined core.
- After reset, a hardware clear FSM zeroes every entry. No `initial` blocks, so the block is synthesis-safe.
- Sits in the decode stage:
  - read ports feed operand fetch;
  - the write port is driven by writeback;
  - the alloc port is driven by issue, marking destinations as pending.

---
 rtl/regfile_sb_pkg.sv | 14 +
 rtl/regfile_sb_scoreboard.sv | 38 +++
 rtl/regfile_sb.sv | 98 +++++++++
 tb/tb_regfile_sb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// clear/run state encoding and the hard-wired zero register index.
package regfile_sb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int X0_IDX   = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy bit per register: issue sets, writeback clears, and a same-cycle
// writeback hides the busy bit on the read side immediately.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREG-1:0] busy;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  always_comb begin
    busy1 = busy[rs1] & ~(clr_en & (clr_idx == rs1));
    busy2 = busy[rs2] & ~(clr_en & (clr_idx == rs2));
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised 2-read/1-write register file with hardware clear sweep after
// reset, optional write-to-read bypass and a per-register busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_rd
);

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   idx;
  logic            clear_we;
  logic            wr_en;
  logic            al_en;
  logic            sb_busy1;
  logic            sb_busy2;
  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      state <= next_state;
      if (clear_we) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (state == ST_CLEAR && idx == AW'(NREG - 1)) next_state = ST_RUN;
  end

  always_comb begin
    ready    = (state == ST_RUN);
    clear_we = (state == ST_CLEAR);
  end

  // Index 0 is hard-wired to zero, so writes and allocs to it are dropped here.
  always_comb begin
    wr_en = ready & we       & (rd       != AW'(X0_IDX));
    al_en = ready & alloc_en & (alloc_rd != AW'(X0_IDX));
  end

  always_ff @(posedge clk) begin
    if (clear_we)   regs[idx] <= '0;
    else if (wr_en) regs[rd]  <= write_data;
  end

  always_comb begin
    if (!ready || rs1 == AW'(X0_IDX))             data1 = '0;
    else if (BYPASS != 0 && we && rd == rs1)      data1 = write_data;
    else                                          data1 = regs[rs1];
  end

  always_comb begin
    if (!ready || rs2 == AW'(X0_IDX))             data2 = '0;
    else if (BYPASS != 0 && we && rd == rs2)      data2 = write_data;
    else                                          data2 = regs[rs2];
  end

  regfile_sb_scoreboard #(.NREG(NREG)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (al_en),
    .set_idx (alloc_rd),
    .clr_en  (wr_en),
    .clr_idx (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );

  always_comb begin
    busy1 = ready & sb_busy1;
    busy2 = ready & sb_busy2;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing and one non-bypassing instance share
// stimulus and are checked every cycle against an array/flag model.
module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, rd, alloc_rd;
  logic            we, alloc_en;
  logic [XLEN-1:0] write_data;

  logic            ready_b, busy1_b, busy2_b;
  logic [XLEN-1:0] data1_b, data2_b;
  logic            ready_n, busy1_n, busy2_n;
  logic [XLEN-1:0] data1_n, data2_n;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .ready(ready_b), .rs1(rs1), .rs2(rs2),
    .data1(data1_b), .data2(data2_b), .busy1(busy1_b), .busy2(busy2_b),
    .we(we), .rd(rd), .write_data(write_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .ready(ready_n), .rs1(rs1), .rs2(rs2),
    .data1(data1_n), .data2(data2_n), .busy1(busy1_n), .busy2(busy2_n),
    .we(we), .rd(rd), .write_data(write_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd)
  );

  // Reference model: contents, pending flags and a count of sweep edges.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  int              m_cnt;
  bit              m_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   = 0;
      m_ready = 1'b0;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NREG) m_ready = 1'b1;
    end else begin
      if (we && rd != 0) begin
        m_mem[rd]  = write_data;
        m_busy[rd] = 1'b0;
      end
      if (alloc_en && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] rs, input bit byp);
    if (rst || !m_ready || rs == 0) return '0;
    if (byp && we && rd == rs)      return write_data;
    return m_mem[rs];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] rs);
    if (rst || !m_ready || rs == 0) return 1'b0;
    return m_busy[rs] && !(we && rd == rs);
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("ready_b", 64'(ready_b), 64'(m_ready && !rst));
      check("ready_n", 64'(ready_n), 64'(m_ready && !rst));
      check("data1_b", data1_b, exp_data(rs1, 1'b1));
      check("data2_b", data2_b, exp_data(rs2, 1'b1));
      check("data1_n", data1_n, exp_data(rs1, 1'b0));
      check("data2_n", data2_n, exp_data(rs2, 1'b0));
      check("busy1_b", 64'(busy1_b), 64'(exp_busy(rs1)));
      check("busy2_b", 64'(busy2_b), 64'(exp_busy(rs2)));
      check("busy1_n", 64'(busy1_n), 64'(exp_busy(rs1)));
      check("busy2_n", 64'(busy2_n), 64'(exp_busy(rs2)));
    end
  end

  task automatic drive(input logic w, input logic [AW-1:0] d, input logic [XLEN-1:0] wd,
                       input logic a, input logic [AW-1:0] ad,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    @(posedge clk);
    #1;
    we = w; rd = d; write_data = wd;
    alloc_en = a; alloc_rd = ad;
    rs1 = r1; rs2 = r2;
    #2;
  endtask

  // Counts rising edges until ready; release must happen between edges.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_b) break;
    end
    check(name, 64'(n), 64'(NREG));
  endtask

  initial begin
    rst = 1'b1;
    we = 0; rd = 0; write_data = 0; alloc_en = 0; alloc_rd = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_ready", 64'(ready_b), 64'd0);
    rst = 1'b0;
    chk_on = 1'b1;
    wait_ready("sweep_edges");

    for (int i = 1; i < NREG; i++) begin
      drive(0, 0, 0, 0, 0, AW'(i), AW'(i));
      check("swept_zero", data1_b | data2_n, 64'd0);
    end

    // Same-cycle write/read of rd=5 on both flavours, then held read.
    drive(1, 5, 64'hDEAD_BEEF, 0, 0, 5, 0);
    check("byp_same", data1_b, 64'hDEAD_BEEF);
    check("nob_same", data1_n, 64'd0);
    drive(0, 0, 0, 0, 0, 5, 0);
    check("byp_next", data1_b, 64'hDEAD_BEEF);
    check("nob_next", data1_n, 64'hDEAD_BEEF);

    drive(1, 0, 64'h1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("x0_data", data1_b | data2_b | data1_n, 64'd0);
    check("x0_busy", 64'({busy1_b, busy2_b}), 64'd0);

    drive(0, 0, 0, 1, 7, 0, 7);
    drive(0, 0, 0, 0, 0, 0, 7);
    check("sb_set", 64'(busy2_b), 64'd1);
    drive(1, 7, 64'h77, 0, 0, 0, 7);
    check("sb_clr_same", 64'(busy2_b), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 7);
    check("sb_clr_after", 64'(busy2_b), 64'd0);

    drive(1, 9, 64'h9999, 1, 9, 9, 0);
    drive(0, 0, 0, 0, 0, 9, 9);
    check("wa_data", data1_n, 64'h9999);
    check("wa_busy", 64'(busy2_b), 64'd1);

    drive(1, 3, 64'h55, 1, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 3, 0);
    check("mid_pre_busy", 64'(busy1_b), 64'd1);
    check("mid_pre_data", data1_b, 64'h55);
    rst = 1'b1;
    #1;
    check("mid_busy_drop", 64'(busy1_b), 64'd0);
    check("mid_ready", 64'(ready_b), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    wait_ready("mid_sweep_edges");
    #2;
    check("mid_data_zero", data1_b, 64'd0);

    // Random traffic on a narrow index range so collisions are frequent.
    for (int c = 0; c < 1500; c++) begin
      logic [AW-1:0] d, ad, r1, r2;
      d  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ad = AW'($urandom_range(0, 7));
      r1 = AW'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : AW'($urandom);
      drive(1'($urandom), d, {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0), ad, r1, r2);
      if (c == 700) begin
        rst = 1'b1;
        #3;
        rst = 1'b0;
      end
    end

    @(posedge clk);
    #3;
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
